// File: rtl/fp_align_shift.sv
// -----------------------------------------------------------------------------
// fp_align_shift
//   Sequential mantissa-alignment stage of the FPU add/sub path. Picks the
//   larger-exponent significand and right-shifts the smaller one by the
//   exponent difference. The shift advances at most STEP bits per cycle.
//   Bits shifted out are collected in a sticky bit. Results go to the mantissa
//   adder through a valid/ready handshake.
//
//   Optional feature macro: FP_ALIGN_SAT_EN
//     defined   : exp_diff >= 27 finishes in one cycle. shift_reg becomes 0 and
//                 sticky becomes |small.
//     undefined : the shifter walks the full exp_diff distance. The result is
//                 bit-identical; only the latency is longer.
//
// Parameters
//   STEP        maximum shift distance per cycle (1..8)
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream operands valid
//   in_ready    stage idle and able to accept operands (registered)
//   exp_diff    exponent-difference magnitude, 0..127
//   swap        1: operand b has the larger exponent
//   mant_a/b    24-bit significands with the hidden bit included
//   out_valid   aligned result valid (registered)
//   out_ready   downstream accepts the result
//   mant_big    {larger significand, 3'b000}
//   mant_small  aligned smaller significand, with sticky folded into bit 0
//   swap_out    registered copy of swap
// -----------------------------------------------------------------------------
module fp_align_shift #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  exp_diff,
    input  logic        swap,
    input  logic [23:0] mant_a,
    input  logic [23:0] mant_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [26:0] mant_big,
    output logic [26:0] mant_small,
    output logic        swap_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [23:0] r_big;
    logic [26:0] r_shift;
    logic        r_sticky;
    logic [6:0]  r_rem;
    logic        r_swap;

    logic [23:0] w_small;
    logic        w_sat;
    logic [6:0]  w_deff;
    logic [3:0]  w_k;
    logic [26:0] w_mask;
    logic [26:0] w_shifted;
    logic        w_lost;

    // Operand selection and effective shift distance at accept time.
    always_comb begin
        w_small = swap ? mant_a : mant_b;
`ifdef FP_ALIGN_SAT_EN
        // At 27 or more the whole 27-bit field drops into sticky.
        w_sat   = (exp_diff >= 7'd27);
`else
        w_sat   = 1'b0;
`endif
        w_deff  = w_sat ? 7'd0 : exp_diff;
    end

    // One shift step: k = min(STEP, rem). The mask keeps the k bits that drop off.
    always_comb begin
        w_k       = (r_rem < 7'(STEP)) ? r_rem[3:0] : 4'(STEP);
        w_mask    = (27'd1 << w_k) - 27'd1;
        w_shifted = r_shift >> w_k;
        w_lost    = |(r_shift & w_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_big       <= '0;
            r_shift     <= '0;
            r_sticky    <= 1'b0;
            r_rem       <= '0;
            r_swap      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_big    <= swap ? mant_b : mant_a;
                        r_shift  <= w_sat ? 27'd0 : {w_small, 3'b000};
                        r_sticky <= w_sat & (|w_small);
                        r_rem    <= w_deff;
                        r_swap   <= swap;
                        r_in_ready <= 1'b0;
                        if (w_deff == 7'd0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_shift  <= w_shifted;
                    r_sticky <= r_sticky | w_lost;
                    r_rem    <= r_rem - 7'(w_k);
                    if (r_rem == 7'(w_k)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE takes one full cycle, so there is no same-cycle re-accept.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign mant_big   = {r_big, 3'b000};
    assign mant_small = {r_shift[26:1], r_shift[0] | r_sticky};
    assign swap_out   = r_swap;

endmodule

// File: doc/fp_align_shift.md
# fp_align_shift

Sequential mantissa-alignment stage of the FPU add/sub path. It sits directly downstream of the 7-bit exponent subtractor and consumes that unit's exponent-difference magnitude and swap indication. It selects the larger- and smaller-exponent mantissas, then right-shifts the smaller one by the exponent difference, a bounded number of bits per cycle. Shifted-out bits are folded into a sticky bit. Results are delivered through a valid/ready handshake to the mantissa adder.

## Interface

Parameters:
- STEP, default 4: maximum shift distance per cycle. Legal range 1..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream operands valid
- in_ready  out  1  stage can accept operands
- exp_diff  in  7  unsigned exponent-difference magnitude, 0..127
- swap  in  1  1: operand b has the larger exponent; 0: operand a has the larger exponent (or the exponents are equal)
- mant_a  in  24  operand a significand, hidden bit included
- mant_b  in  24  operand b significand, hidden bit included
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- mant_big  out  27  larger-exponent significand, formatted {mant, 3'b000}
- mant_small  out  27  aligned smaller significand: {shift_reg[26:1], shift_reg[0] | sticky}
- swap_out  out  1  registered copy of swap

## Operation

- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1, in_ready=0.
- Accept occurs when in_valid && in_ready in IDLE. On accept, register the following:
  - big = swap ? mant_b : mant_a
  - shift_reg = {small, 3'b000}, where small is the other significand
  - sticky = 0
  - rem = d_eff
  - swap_out = swap
- Next state after accept: DONE if rem==0, otherwise SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, rem)
  - shift_reg >>= k
  - sticky |= OR of the k bits shifted out
  - rem -= k
  - Go to DONE when rem becomes 0.
- DONE: outputs hold stable until out_ready. The cycle with out_valid && out_ready returns the FSM to IDLE. No new operand is accepted in that same cycle.
- d_eff computation (see Configuration): with saturation enabled, exp_diff >= 27 produces the following on accept, with rem=0:
  - shift_reg = 0
  - sticky = |small
- Zero significands need no special case. A shift_reg of 0 gives mant_small=0.
- Reset value of all outputs and registers is zero: out_valid=0, mant_big=0, mant_small=0, swap_out=0. FSM resets to IDLE, so in_ready=1 in the cycle after reset deasserts.
- Reset asserted in any state, including mid-SHIFT or DONE with out_ready=0, aborts the operation. No output is produced for the aborted operand.
- in_valid and in_ready are ignored outside IDLE. Upstream must hold its operands until accepted.

## Timing

- Accept edge E0. out_valid is high starting the cycle after edge E0 + ceil(d_eff/STEP).
  - d_eff=0: out_valid is high the cycle after E0 (1-cycle latency).
- Maximum latency:
  - With saturation: ceil(26/STEP)+1 cycles, i.e. 8 cycles for STEP=4.
  - Without saturation: ceil(127/STEP)+1 cycles, i.e. 33 cycles for STEP=4.
- Throughput is one operation per (latency + 1) cycles at best, because DONE→IDLE costs one cycle.
- All outputs are registered. No combinational path from in_* to out_*, or from out_ready to in_ready.

## Configuration

- FP_ALIGN_SAT_EN defined: d_eff = (exp_diff >= 27) ? 0 : exp_diff. Large differences resolve in one cycle via the saturation path.
- FP_ALIGN_SAT_EN undefined: d_eff = exp_diff, and the shifter iterates the full distance. mant_small is bit-identical to the defined case; only latency differs.

## Test plan

- Equal exponents:
  - Stimulus: exp_diff=0, swap=0, mant_a=0x800000, mant_b=0xC00000.
  - Required: out_valid the cycle after accept; mant_big=0x4000000, mant_small=0x6000000, swap_out=0.
- Multi-cycle shift with sticky (STEP=4):
  - Stimulus: exp_diff=5, swap=0, mant_b=0x800001.
  - Required: two SHIFT cycles; mant_small=0x0200001 (sticky set); out_valid 2 cycles after accept.
- Swap path:
  - Stimulus: exp_diff=3, swap=1, mant_a=0x800000, mant_b=0xFFFFFF.
  - Required: mant_big=0x7FFFFF8, mant_small=0x0800000, swap_out=1.
- Saturation boundary:
  - exp_diff=26, mant=0x800000 → mant_small=0x0000001, sticky 0.
  - exp_diff=27 → mant_small=0x0000001 via sticky.
  - Latency: with FP_ALIGN_SAT_EN, the exp_diff=27 case completes in 1 cycle; without it, ceil(27/STEP)+1 cycles.
- Backpressure:
  - Stimulus: out_ready held low 5 cycles in DONE while in_valid=1 with new operands.
  - Required: outputs stable; in_ready=0; the new operand is accepted only after the handshake cycle plus one.
- Reset mid-operation:
  - Stimulus: exp_diff=100 with FP_ALIGN_SAT_EN undefined; assert rst in the 3rd SHIFT cycle.
  - Required: next cycle out_valid=0, in_ready=1, all outputs 0.
